// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue between the PC / instruction memory
// and the IF/ID register. Keeps a single fetch request outstanding to a
// handshaked memory, buffers up to DEPTH words, each tagged with its PC+4,
// and hands them to ID in order over a valid/ready interface. A redirect from
// ID flushes the queue and restarts fetch at the target. Any response that is
// still in flight at that point is thrown away.
//
// Optional build macro: FETCH_QUEUE_BYPASS_EN. When it is defined and the
// queue is empty, an acked word is forwarded to deq_* in the same cycle.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   redirect           flush the queue and restart fetch at redirect_pc
//   redirect_pc        new fetch address
//   imem_req           fetch request, stays high until imem_ack
//   imem_addr          fetch address, held stable while imem_req=1
//   imem_ack           memory response valid (meaningful while imem_req=1)
//   imem_rdata         instruction word returned with imem_ack
//   deq_valid          head entry available
//   deq_ready          ID accepts the head entry
//   deq_instr          head instruction word
//   deq_pc_plus4       head entry's fetch address + 4
//   count              current occupancy

module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    output logic                       imem_req,
    output logic [31:0]                imem_addr,
    input  logic                       imem_ack,
    input  logic [31:0]                imem_rdata,
    output logic                       deq_valid,
    input  logic                       deq_ready,
    output logic [31:0]                deq_instr,
    output logic [31:0]                deq_pc_plus4,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   req_addr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   pc4_q   [DEPTH];

    logic          ack_ok;
    logic          enq;
    logic          deq;
    logic [CW-1:0] next_count;

    assign imem_addr = req_addr;

    // A response that is wanted and not overridden by a redirect.
    assign ack_ok = (state == WAIT) && imem_ack && !redirect;

    // Only stored entries are dequeued. A bypassed word is not counted here.
    assign deq = (count != '0) && deq_ready && !redirect;

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass;

    // When the queue is empty, the arriving word goes straight to the head.
    assign bypass       = ack_ok && (count == '0);
    assign deq_valid    = (count != '0) || bypass;
    assign deq_instr    = bypass ? imem_rdata : instr_q[rd_ptr];
    assign deq_pc_plus4 = bypass ? (req_addr + 32'd4) : pc4_q[rd_ptr];
    assign enq          = ack_ok && !(bypass && deq_ready);
`else
    assign deq_valid    = (count != '0);
    assign deq_instr    = instr_q[rd_ptr];
    assign deq_pc_plus4 = pc4_q[rd_ptr];
    assign enq          = ack_ok;
`endif

    // Occupancy after this cycle's enqueue/dequeue. It decides whether WAIT
    // can issue the next request back-to-back.
    always_comb begin
        next_count = count;
        if (enq && !deq)
            next_count = count + CW'(1);
        else if (!enq && deq)
            next_count = count - CW'(1);
    end

    // Queue storage, pointers and the fetch FSM. A redirect overrides
    // everything else: the same-cycle enqueue and dequeue are dropped, and an
    // unacked request is kept on the bus until it can be discarded in DROP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            imem_req <= 1'b0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= 32'd0;
                pc4_q[i]   <= 32'd0;
            end
        end else if (redirect) begin
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fetch_pc <= redirect_pc;
            case (state)
                WAIT: begin
                    if (imem_ack) begin
                        state    <= IDLE;
                        imem_req <= 1'b0;
                    end else begin
                        state    <= DROP;
                    end
                end
                DROP:    state <= DROP;
                default: state <= IDLE;
            endcase
        end else begin
            if (enq) begin
                instr_q[wr_ptr] <= imem_rdata;
                pc4_q[wr_ptr]   <= req_addr + 32'd4;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (deq)
                rd_ptr <= rd_ptr + PW'(1);
            count <= next_count;

            case (state)
                IDLE: begin
                    if (count < FULL) begin
                        state    <= WAIT;
                        imem_req <= 1'b1;
                        req_addr <= fetch_pc;
                        fetch_pc <= fetch_pc + 32'd4;
                    end
                end
                WAIT: begin
                    if (imem_ack) begin
                        if (next_count < FULL) begin
                            req_addr <= fetch_pc;
                            fetch_pc <= fetch_pc + 32'd4;
                        end else begin
                            state    <= IDLE;
                            imem_req <= 1'b0;
                        end
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        state    <= IDLE;
                        imem_req <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: testbench for fetch_queue (DEPTH=4, RESET_PC=0, default
// build without FETCH_QUEUE_BYPASS_EN). A latency-configurable instruction
// memory drives the DUT. A queue-based reference model predicts every
// observable output.

module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        deq_valid;
    logic        deq_ready;
    logic [31:0] deq_instr;
    logic [31:0] deq_pc_plus4;
    logic [$clog2(DEPTH+1)-1:0] count;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .deq_valid    (deq_valid),
        .deq_ready    (deq_ready),
        .deq_instr    (deq_instr),
        .deq_pc_plus4 (deq_pc_plus4),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } entry_t;

    entry_t      mq[$];
    logic [31:0] m_fetch_pc;
    logic [31:0] m_addr;
    bit          m_pend;
    bit          m_stale;
    int          wait_cnt;
    int          lat_lo;
    int          lat_hi;
    int          vectors;
    int          miscompares;
    bit          found;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("imem_req", {31'b0, imem_req}, {31'b0, m_pend});
        check("imem_addr", imem_addr, m_addr);
        check("count", 32'(count), 32'(mq.size()));
        check("deq_valid", {31'b0, deq_valid}, {31'b0, (mq.size() != 0)});
        if (mq.size() != 0) begin
            check("deq_instr", deq_instr, mq[0].instr);
            check("deq_pc_plus4", deq_pc_plus4, mq[0].pc4);
        end
    endtask

    task automatic check_reset_values();
        check("rst_imem_req", {31'b0, imem_req}, 32'd0);
        check("rst_imem_addr", imem_addr, RESET_PC);
        check("rst_count", 32'(count), 32'd0);
        check("rst_deq_valid", {31'b0, deq_valid}, 32'd0);
        check("rst_deq_instr", deq_instr, 32'd0);
        check("rst_deq_pc_plus4", deq_pc_plus4, 32'd0);
    endtask

    task automatic model_reset();
        mq.delete();
        m_fetch_pc = RESET_PC;
        m_addr     = RESET_PC;
        m_pend     = 1'b0;
        m_stale    = 1'b0;
        wait_cnt   = 0;
    endtask

    task automatic issue();
        m_pend     = 1'b1;
        m_addr     = m_fetch_pc;
        m_fetch_pc = m_fetch_pc + 32'd4;
    endtask

    // One clock cycle, entered and left on a falling edge: compare outputs,
    // drive inputs (memory responds after its latency), then advance the model.
    task automatic applyStimulus(input bit redir, input logic [31:0] rpc, input bit rdy);
        bit     ack;
        int     sz;
        entry_t e;
        check_outputs();
        ack = m_pend && (wait_cnt == 0);
        if (m_pend && wait_cnt > 0)
            wait_cnt--;
        if (ack)
            wait_cnt = $urandom_range(lat_hi, lat_lo);
        redirect    = redir;
        redirect_pc = rpc;
        deq_ready   = rdy;
        imem_ack    = ack;
        imem_rdata  = ack ? word_at(m_addr) : $urandom();
        if (redir) begin
            mq.delete();
            m_fetch_pc = rpc;
            if (m_pend && !m_stale) begin
                if (ack) m_pend = 1'b0;
                else     m_stale = 1'b1;
            end
        end else begin
            sz = mq.size();
            if (sz != 0 && rdy)
                void'(mq.pop_front());
            if (!m_pend) begin
                if (sz < DEPTH) issue();
            end else if (ack) begin
                m_pend = 1'b0;
                if (m_stale) begin
                    m_stale = 1'b0;
                end else begin
                    e.instr = word_at(m_addr);
                    e.pc4   = m_addr + 32'd4;
                    mq.push_back(e);
                    if (mq.size() < DEPTH) issue();
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'd0;
        deq_ready   = 1'b0;
        lat_lo      = 0;
        lat_hi      = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;

        // Zero-wait memory, consumer always ready.
        repeat (20) applyStimulus(1'b0, 32'd0, 1'b1);

        // Consumer stalls until the queue fills, then drains.
        repeat (10) applyStimulus(1'b0, 32'd0, 1'b0);
        repeat (12) applyStimulus(1'b0, 32'd0, 1'b1);

        // 3-cycle memory: redirect to 0x100 one cycle after the 0x8 request.
        lat_lo = 2;
        lat_hi = 2;
        applyStimulus(1'b1, 32'h0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_pend && !m_stale && m_addr == 32'h8) found = 1'b1;
            else applyStimulus(1'b0, 32'd0, 1'b1);
        end
        vectors++;
        assert (found) else begin
            miscompares++;
            $error("FAIL reach_req_0x8: observed %0d expected %0d", found, 1);
        end
        applyStimulus(1'b0, 32'd0, 1'b1);
        applyStimulus(1'b1, 32'h100, 1'b1);
        repeat (15) applyStimulus(1'b0, 32'd0, 1'b1);

        // Two back-to-back redirects while a request is still unacked.
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_pend && !m_stale && wait_cnt >= 1) found = 1'b1;
            else applyStimulus(1'b0, 32'd0, 1'b1);
        end
        vectors++;
        assert (found) else begin
            miscompares++;
            $error("FAIL reach_wait: observed %0d expected %0d", found, 1);
        end
        applyStimulus(1'b1, 32'h100, 1'b1);
        applyStimulus(1'b1, 32'h200, 1'b1);
        repeat (12) applyStimulus(1'b0, 32'd0, 1'b1);

        // Asynchronous reset with three entries queued and a request pending.
        lat_lo = 0;
        lat_hi = 0;
        applyStimulus(1'b1, 32'h40, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (mq.size() == 3 && m_pend && !m_stale) found = 1'b1;
            else applyStimulus(1'b0, 32'd0, 1'b0);
        end
        vectors++;
        assert (found) else begin
            miscompares++;
            $error("FAIL reach_count3: observed %0d expected %0d", found, 1);
        end
        #2 rst_n = 1'b0;
        #1 check_reset_values();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) applyStimulus(1'b0, 32'd0, 1'b1);

        // Randomized traffic, including redirects near the address wrap.
        lat_lo = 0;
        lat_hi = 3;
        for (int i = 0; i < 600; i++) begin
            bit          rd;
            logic [31:0] pc;
            rd = ($urandom_range(99, 0) < 8);
            pc = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF4 : ($urandom() & 32'h0000_0FFC);
            applyStimulus(rd, pc, ($urandom_range(99, 0) < 60));
        end
        check_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
